// File: rtl/fetch_pkg.sv
// Shared widths, FIFO depth, FSM state encoding and FIFO entry layout
// for the instruction fetch unit.
package fetch_pkg;
    localparam int PC_W        = 72;
    localparam int INSTR_W     = 60;
    localparam int FETCH_DEPTH = 2;
    localparam int CNT_W       = $clog2(FETCH_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Shift-register FIFO: entry 0 is always the head, so an emptied FIFO keeps
// showing the last word it held.
module fetch_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [WIDTH-1:0]           i_data,
    output logic [WIDTH-1:0]           o_head,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CNT_W-1:0] r_count;
    logic             w_pop;
    logic             w_push;
    logic [CNT_W-1:0] w_wr_idx;

    // A pop frees a slot in the same cycle, so push-while-full is legal with a pop.
    assign w_pop    = i_pop && (r_count != '0);
    assign w_push   = i_push && ((r_count != CNT_W'(DEPTH)) || w_pop);
    assign w_wr_idx = r_count - CNT_W'(w_pop);

    // NOTE: state uses non-blocking assignments so every slot samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
            // NOTE: storage is reset because the head drives outputs that must read 0 in reset.
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_flush) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (w_pop && (CNT_W'(i + 1) < r_count)) r_mem[i] <= r_mem[i+1];
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (w_push && (CNT_W'(i) == w_wr_idx)) r_mem[i] <= i_data;
            end
        end
    end

    assign o_head  = r_mem[0];
    assign o_count = r_count;
endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: one outstanding memory request, 2-entry prefetch FIFO,
// redirect flushes queued words and discards any in-flight response.
module instr_fetch_unit
    import fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [PC_W-1:0]    pc,
    input  logic               redirect,
    output logic               pc_adv,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [PC_W-1:0]    if_pc,
    input  logic               id_ready
);
    fetch_state_t     r_state;
    fetch_state_t     w_state_nxt;
    logic [PC_W-1:0]  r_addr;
    logic [PC_W-1:0]  r_saved_pc;
    logic             r_discard;
    logic             w_discard_nxt;
    logic             w_capture;
    logic             w_push;
    logic             w_pop;
    logic [CNT_W-1:0] w_count;
    fetch_entry_t     w_head;
    fetch_entry_t     w_push_entry;

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        w_state_nxt   = r_state;
        w_discard_nxt = r_discard;
        w_capture     = 1'b0;
        w_push        = 1'b0;
        imem_req      = 1'b0;
        pc_adv        = 1'b0;
        case (r_state)
            IDLE: begin
                if ((w_count < CNT_W'(FETCH_DEPTH)) && !redirect) begin
                    w_state_nxt = REQ;
                    w_capture   = 1'b1;
                end
            end
            REQ: begin
                imem_req = 1'b1;
                if (imem_gnt) begin
                    w_state_nxt   = WAIT;
                    w_discard_nxt = redirect;
                    pc_adv        = !redirect;
                end else if (redirect) begin
                    w_state_nxt = IDLE;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    w_push        = !(r_discard || redirect);
                    w_discard_nxt = 1'b0;
                    w_state_nxt   = IDLE;
                end else if (redirect) begin
                    w_discard_nxt = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_saved_pc <= '0;
            r_discard  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_discard <= w_discard_nxt;
            if (w_capture) begin
                r_addr     <= pc;
                r_saved_pc <= pc;
            end
        end
    end

    assign w_push_entry = '{pc: r_saved_pc, instr: imem_rdata};
    assign w_pop        = if_valid && id_ready;

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (FETCH_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (redirect),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_push_entry),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign imem_addr = r_addr;
    assign if_valid  = (w_count != '0);
    assign if_instr  = w_head.instr;
    assign if_pc     = w_head.pc;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a cycle table for the fill/stall/drain
// flow, then hand sequences for redirect, push+pop and reset corner cases.
module tb_instr_fetch_unit;
    logic         clk = 1'b0;
    logic         rst;
    logic [71:0]  pc;
    logic         redirect;
    logic         pc_adv;
    logic         imem_req;
    logic [71:0]  imem_addr;
    logic         imem_gnt;
    logic         imem_rvalid;
    logic [59:0]  imem_rdata;
    logic         if_valid;
    logic [59:0]  if_instr;
    logic [71:0]  if_pc;
    logic         id_ready;

    int n_checks = 0;
    int n_errors = 0;

    instr_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .redirect    (redirect),
        .pc_adv      (pc_adv),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .id_ready    (id_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [71:0] pc;
        logic        redirect;
        logic        gnt;
        logic        rvalid;
        logic [59:0] rdata;
        logic        rdy;
        logic        e_adv;
        logic        e_req;
        logic [71:0] e_addr;
        logic        e_valid;
        logic [71:0] e_ipc;
        logic [59:0] e_instr;
    } vec_t;

    vec_t vecs [13];

    function automatic vec_t mk(input logic [71:0] p, input logic rd, input logic g,
                                input logic rv, input logic [59:0] d, input logic ry,
                                input logic adv, input logic req, input logic [71:0] addr,
                                input logic vld, input logic [71:0] ipc, input logic [59:0] ins);
        vec_t v;
        v.pc = p; v.redirect = rd; v.gnt = g; v.rvalid = rv; v.rdata = d; v.rdy = ry;
        v.e_adv = adv; v.e_req = req; v.e_addr = addr;
        v.e_valid = vld; v.e_ipc = ipc; v.e_instr = ins;
        return v;
    endfunction

    task automatic check(input string name, input logic [131:0] act, input logic [131:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [71:0] p, input logic rd, input logic g,
                         input logic rv, input logic [59:0] d, input logic ry);
        pc = p; redirect = rd; imem_gnt = g; imem_rvalid = rv; imem_rdata = d; id_ready = ry;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        pc = '0; redirect = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
        imem_rdata = '0; id_ready = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        // Reset values, with stray handshakes that must be ignored.
        rst = 1'b0;
        pc = 72'h55; redirect = 1'b0; imem_gnt = 1'b1; imem_rvalid = 1'b1;
        imem_rdata = 60'h123; id_ready = 1'b1;
        tick();
        tick();
        check("rst.req",   imem_req,  1'b0);
        check("rst.adv",   pc_adv,    1'b0);
        check("rst.valid", if_valid,  1'b0);
        check("rst.addr",  imem_addr, 72'h0);
        check("rst.ipc",   if_pc,     72'h0);
        check("rst.instr", if_instr,  60'h0);

        // Fill, stall while full, then one id_ready pulse releases a third request.
        vecs[0]  = mk(72'h10, 0, 0, 0, 60'h0,   0, 0, 0, 72'h00, 0, 72'h00, 60'h0);
        vecs[1]  = mk(72'h10, 0, 0, 0, 60'h0,   0, 0, 1, 72'h10, 0, 72'h00, 60'h0);
        vecs[2]  = mk(72'h10, 0, 1, 0, 60'h0,   0, 1, 1, 72'h10, 0, 72'h00, 60'h0);
        vecs[3]  = mk(72'h11, 0, 0, 0, 60'h0,   0, 0, 0, 72'h10, 0, 72'h00, 60'h0);
        vecs[4]  = mk(72'h11, 0, 0, 1, 60'hABC, 0, 0, 0, 72'h10, 0, 72'h00, 60'h0);
        vecs[5]  = mk(72'h11, 0, 0, 0, 60'h0,   0, 0, 0, 72'h10, 1, 72'h10, 60'hABC);
        vecs[6]  = mk(72'h11, 0, 1, 0, 60'h0,   0, 1, 1, 72'h11, 1, 72'h10, 60'hABC);
        vecs[7]  = mk(72'h12, 0, 0, 1, 60'hBBB, 0, 0, 0, 72'h11, 1, 72'h10, 60'hABC);
        vecs[8]  = mk(72'h12, 0, 0, 0, 60'h0,   0, 0, 0, 72'h11, 1, 72'h10, 60'hABC);
        vecs[9]  = mk(72'h12, 0, 1, 0, 60'h0,   0, 0, 0, 72'h11, 1, 72'h10, 60'hABC);
        vecs[10] = mk(72'h12, 0, 0, 0, 60'h0,   1, 0, 0, 72'h11, 1, 72'h10, 60'hABC);
        vecs[11] = mk(72'h12, 0, 0, 0, 60'h0,   0, 0, 0, 72'h11, 1, 72'h11, 60'hBBB);
        vecs[12] = mk(72'h12, 0, 0, 0, 60'h0,   0, 0, 1, 72'h12, 1, 72'h11, 60'hBBB);

        do_reset();
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].pc, vecs[i].redirect, vecs[i].gnt, vecs[i].rvalid,
                  vecs[i].rdata, vecs[i].rdy);
            check($sformatf("v%0d.adv", i),   pc_adv,    vecs[i].e_adv);
            check($sformatf("v%0d.req", i),   imem_req,  vecs[i].e_req);
            check($sformatf("v%0d.addr", i),  imem_addr, vecs[i].e_addr);
            check($sformatf("v%0d.valid", i), if_valid,  vecs[i].e_valid);
            if (vecs[i].e_valid) begin
                check($sformatf("v%0d.ipc", i),   if_pc,    vecs[i].e_ipc);
                check($sformatf("v%0d.instr", i), if_instr, vecs[i].e_instr);
            end
            tick();
        end

        // Redirect while waiting: the late response is dropped, refetch from 0x40.
        do_reset();
        drive(72'h20, 0, 0, 0, 60'h0, 0); tick();
        drive(72'h20, 0, 1, 0, 60'h0, 0); check("w.adv_gnt", pc_adv, 1'b1); tick();
        drive(72'h40, 1, 0, 0, 60'h0, 0); check("w.adv_redir", pc_adv, 1'b0);
        check("w.req_wait", imem_req, 1'b0); tick();
        drive(72'h40, 0, 0, 1, 60'hDEAD, 0); tick();
        drive(72'h40, 0, 0, 0, 60'h0, 0); check("w.valid", if_valid, 1'b0);
        check("w.req_idle", imem_req, 1'b0); tick();
        drive(72'h40, 0, 0, 0, 60'h0, 0); check("w.req_new", imem_req, 1'b1);
        check("w.addr_new", imem_addr, 72'h40); check("w.valid2", if_valid, 1'b0);

        // Redirect on the grant cycle: no pc_adv, response discarded.
        do_reset();
        drive(72'h30, 0, 0, 0, 60'h0, 0); tick();
        drive(72'h50, 1, 1, 0, 60'h0, 0); check("g.adv", pc_adv, 1'b0);
        check("g.req", imem_req, 1'b1); tick();
        drive(72'h50, 0, 0, 1, 60'h777, 0); tick();
        drive(72'h50, 0, 0, 0, 60'h0, 0); check("g.valid", if_valid, 1'b0);
        check("g.req_idle", imem_req, 1'b0); tick();
        drive(72'h50, 0, 0, 0, 60'h0, 0); check("g.addr_new", imem_addr, 72'h50);
        check("g.valid2", if_valid, 1'b0);

        // One entry held, push and pop together, then redirect in REQ flushes.
        do_reset();
        drive(72'h60, 0, 0, 0, 60'h0, 0); tick();
        drive(72'h60, 0, 1, 0, 60'h0, 0); tick();
        drive(72'h61, 0, 0, 1, 60'h111, 0); tick();
        drive(72'h61, 0, 0, 0, 60'h0, 0); check("pp.valid1", if_valid, 1'b1);
        check("pp.ipc1", if_pc, 72'h60); check("pp.instr1", if_instr, 60'h111); tick();
        drive(72'h61, 0, 1, 0, 60'h0, 0); check("pp.addr2", imem_addr, 72'h61);
        check("pp.adv2", pc_adv, 1'b1); tick();
        drive(72'h62, 0, 0, 1, 60'h222, 1); check("pp.ipc_pre", if_pc, 72'h60); tick();
        drive(72'h62, 0, 0, 0, 60'h0, 0); check("pp.valid_post", if_valid, 1'b1);
        check("pp.ipc_post", if_pc, 72'h61); check("pp.instr_post", if_instr, 60'h222); tick();
        drive(72'h62, 1, 0, 0, 60'h0, 0); check("pp.req_cnt1", imem_req, 1'b1);
        check("pp.addr3", imem_addr, 72'h62); tick();
        drive(72'h80, 0, 0, 0, 60'h0, 0); check("fl.valid", if_valid, 1'b0);
        check("fl.req_drop", imem_req, 1'b0); check("fl.ipc_hold", if_pc, 72'h61); tick();
        drive(72'h80, 0, 0, 0, 60'h0, 0); check("fl.req_new", imem_req, 1'b1);
        check("fl.addr_new", imem_addr, 72'h80);

        // Reset asserted in WAIT; a response after release must not be pushed.
        do_reset();
        drive(72'h70, 0, 0, 0, 60'h0, 0); tick();
        drive(72'h70, 0, 1, 0, 60'h0, 0); tick();
        rst = 1'b0; pc = 72'h71; imem_gnt = 1'b0;
        #1;
        check("r.req", imem_req, 1'b0); check("r.addr", imem_addr, 72'h0);
        check("r.valid", if_valid, 1'b0);
        tick();
        rst = 1'b1; imem_rvalid = 1'b1; imem_rdata = 60'h999;
        #1;
        check("r.req_rel", imem_req, 1'b0);
        tick();
        check("r.valid_a", if_valid, 1'b0); check("r.req_a", imem_req, 1'b1);
        check("r.addr_a", imem_addr, 72'h71);
        tick();
        imem_rvalid = 1'b0;
        #1;
        check("r.valid_b", if_valid, 1'b0); check("r.req_b", imem_req, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
